// File: rtl/iob_axis_pkt_arbiter_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter.
package iob_axis_pkt_arbiter_pkg;

  // Arbiter FSM encoding: IDLE scans for a requester, GRANT passes one packet through.
  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_t;

  // Width of a requester index; never narrower than one bit.
  function automatic int unsigned tid_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/iob_rr_prio_enc.sv
// Rotating first-set priority encoder: returns the first set bit of req at or
// after ptr, scanning upward and wrapping modulo N.
module iob_rr_prio_enc #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         found
);

  // One extra bit so ptr + offset cannot overflow before the wrap.
  logic [W:0] pos;

  // Scan offsets 0..N-1 from ptr; the lowest offset with a request wins.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pos = {1'b0, ptr} + (W + 1)'(i);
      if (pos >= (W + 1)'(N)) begin
        pos = pos - (W + 1)'(N);
      end
      if (!found && req[pos[W-1:0]]) begin
        found = 1'b1;
        idx   = pos[W-1:0];
      end
    end
  end

endmodule

// File: rtl/iob_axis_pkt_arbiter.sv
// Round-robin AXI-Stream packet arbiter: merges N_IN requesters into one stream,
// holding each grant for a whole packet.
// Optional stall watchdog: define IOB_AXIS_PKT_ARBITER_TIMEOUT_EN to build it.
module iob_axis_pkt_arbiter
  import iob_axis_pkt_arbiter_pkg::*;
#(
  parameter int unsigned N_IN      = 4,
  parameter int unsigned TDATA_W   = 8,
  parameter int unsigned TIMEOUT_W = 16
) (
  input  logic                         clk_i,
  input  logic                         cke_i,
  input  logic                         rst_i,
  input  logic                         enable_i,
  input  logic [N_IN-1:0]              s_tvalid_i,
  input  logic [N_IN*TDATA_W-1:0]      s_tdata_i,
  input  logic [N_IN-1:0]              s_tlast_i,
  output logic [N_IN-1:0]              s_tready_o,
  output logic                         m_tvalid_o,
  output logic [TDATA_W-1:0]           m_tdata_o,
  output logic                         m_tlast_o,
  input  logic                         m_tready_i,
  output logic [tid_width(N_IN)-1:0]   m_tid_o,
  output logic                         pkt_done_o,
  input  logic [TIMEOUT_W-1:0]         timeout_cyc_i,
  output logic                         timeout_o
);

  localparam int unsigned TidW = tid_width(N_IN);

  state_t            state_q, state_d;
  logic [TidW-1:0]   grant_q, grant_d;
  logic [TidW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [TidW-1:0]   next_ptr;
  logic [TidW-1:0]   enc_idx;
  logic              enc_found;
  logic              pkt_done_q, pkt_done_d;
  logic              pass;
  logic              handshake;
  logic              wd_expired;

  iob_rr_prio_enc #(
    .N (N_IN),
    .W (TidW)
  ) u_prio_enc (
    .req   (s_tvalid_i),
    .ptr   (rr_ptr_q),
    .idx   (enc_idx),
    .found (enc_found)
  );

  // Pass-through of the granted requester; blanked in reset and while the
  // clock enable is low so no beat is accepted that the state cannot record.
  always_comb begin
    pass       = (state_q == StGrant) && cke_i && !rst_i;
    s_tready_o = '0;
    if (pass) begin
      s_tready_o[grant_q] = m_tready_i;
    end
    m_tvalid_o = pass && s_tvalid_i[grant_q];
    m_tlast_o  = pass && s_tlast_i[grant_q];
    m_tdata_o  = s_tdata_i[grant_q*TDATA_W +: TDATA_W];
    handshake  = m_tvalid_o && m_tready_i;
  end

  assign m_tid_o    = grant_q;
  assign pkt_done_o = pkt_done_q;

  // Pointer to the requester after the current grant, wrapping at N_IN.
  always_comb begin
    next_ptr = grant_q + 1'b1;
    if (32'(grant_q) == N_IN - 1) begin
      next_ptr = '0;
    end
  end

  // Next-state logic: grant from IDLE, release on tlast handshake or watchdog.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    rr_ptr_d   = rr_ptr_q;
    pkt_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable_i && enc_found) begin
          state_d = StGrant;
          grant_d = enc_idx;
        end
      end
      StGrant: begin
        if (handshake && m_tlast_o) begin
          state_d    = StIdle;
          rr_ptr_d   = next_ptr;
          pkt_done_d = 1'b1;
        end else if (wd_expired) begin
          state_d  = StIdle;
          rr_ptr_d = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        state_q    <= StIdle;
        grant_q    <= '0;
        rr_ptr_q   <= '0;
        pkt_done_q <= 1'b0;
      end else begin
        state_q    <= state_d;
        grant_q    <= grant_d;
        rr_ptr_q   <= rr_ptr_d;
        pkt_done_q <= pkt_done_d;
      end
    end
  end

`ifdef IOB_AXIS_PKT_ARBITER_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wd_q, wd_d;
  logic                 timeout_q;

  // Stall counter: counts GRANT cycles without a handshake; a zero limit disables it.
  always_comb begin
    wd_expired = (state_q == StGrant) && (timeout_cyc_i != '0) &&
                 (wd_q == timeout_cyc_i) && !handshake;
    if ((state_q != StGrant) || handshake || wd_expired) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + 1'b1;
    end
  end

  // Watchdog counter and forced-release pulse.
  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        wd_q      <= '0;
        timeout_q <= 1'b0;
      end else begin
        wd_q      <= wd_d;
        timeout_q <= wd_expired;
      end
    end
  end

  assign timeout_o = timeout_q;
`else
  logic unused_timeout_cyc;

  assign unused_timeout_cyc = ^timeout_cyc_i;
  assign wd_expired         = 1'b0;
  assign timeout_o          = 1'b0;
`endif

endmodule

// File: tb/tb_iob_axis_pkt_arbiter.sv
// Directed bench for iob_axis_pkt_arbiter (N_IN=4, TDATA_W=8).
// Requester k sends data {k, beat} and raises tlast on beat len[k]-1.
module tb_iob_axis_pkt_arbiter;

  logic        clk;
  logic        cke;
  logic        rst;
  logic        enable;
  logic [3:0]  s_tvalid;
  logic [31:0] s_tdata;
  logic [3:0]  s_tlast;
  logic [3:0]  s_tready;
  logic        m_tvalid;
  logic [7:0]  m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic [1:0]  m_tid;
  logic        pkt_done;
  logic [15:0] timeout_cyc;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  logic [3:0] avail;
  int         len  [4];
  int         beat [4];
  logic [3:0] hs_v;

  typedef struct packed {
    logic       v;
    logic [1:0] tid;
    logic       l;
    logic [3:0] rdy;
    logic       done;
    logic       to;
    logic [7:0] dat;
  } obs_t;

  iob_axis_pkt_arbiter #(
    .N_IN      (4),
    .TDATA_W   (8),
    .TIMEOUT_W (16)
  ) dut (
    .clk_i         (clk),
    .cke_i         (cke),
    .rst_i         (rst),
    .enable_i      (enable),
    .s_tvalid_i    (s_tvalid),
    .s_tdata_i     (s_tdata),
    .s_tlast_i     (s_tlast),
    .s_tready_o    (s_tready),
    .m_tvalid_o    (m_tvalid),
    .m_tdata_o     (m_tdata),
    .m_tlast_o     (m_tlast),
    .m_tready_i    (m_tready),
    .m_tid_o       (m_tid),
    .pkt_done_o    (pkt_done),
    .timeout_cyc_i (timeout_cyc),
    .timeout_o     (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t mk(input logic v, input logic [1:0] tid, input logic l,
                              input logic [3:0] rdy, input logic done, input logic [7:0] dat);
    obs_t o;
    o.v    = v;
    o.tid  = tid;
    o.l    = l;
    o.rdy  = rdy;
    o.done = done;
    o.to   = 1'b0;
    o.dat  = dat;
    return o;
  endfunction

  // Data is only meaningful while m_tvalid is high.
  function automatic obs_t observe();
    obs_t o;
    o.v    = m_tvalid;
    o.tid  = m_tid;
    o.l    = m_tlast;
    o.rdy  = s_tready;
    o.done = pkt_done;
    o.to   = timeout;
    o.dat  = m_tvalid ? m_tdata : 8'h00;
    return o;
  endfunction

  task automatic src_drive();
    s_tvalid = avail;
    for (int k = 0; k < 4; k++) begin
      s_tlast[k]        = (beat[k] == len[k] - 1);
      s_tdata[k*8 +: 8] = {4'(k), 4'(beat[k])};
    end
  endtask

  task automatic settle();
    src_drive();
    #1;
  endtask

  task automatic advance();
    hs_v = s_tready & s_tvalid;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (hs_v[k]) beat[k] = (beat[k] == len[k] - 1) ? 0 : beat[k] + 1;
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    cke      = 1'b1;
    enable   = 1'b1;
    m_tready = 1'b1;
    avail    = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      beat[k] = 0;
      len[k]  = 2;
    end
    settle();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst         = 1'b1;
    cke         = 1'b1;
    enable      = 1'b1;
    m_tready    = 1'b1;
    avail       = 4'b1111;
    timeout_cyc = 16'd0;
    for (int k = 0; k < 4; k++) begin
      beat[k] = 0;
      len[k]  = 1;
    end
    settle();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    settle();
    checks++;
    if (m_tvalid !== 1'b0) begin
      errors++; $display("FAIL reset_tvalid got=%b exp=0", m_tvalid);
    end
    checks++;
    if (s_tready !== 4'b0000) begin
      errors++; $display("FAIL reset_tready got=%b exp=0000", s_tready);
    end
    checks++;
    if (m_tid !== 2'd0) begin
      errors++; $display("FAIL reset_tid got=%0d exp=0", m_tid);
    end
    checks++;
    if (pkt_done !== 1'b0) begin
      errors++; $display("FAIL reset_pkt_done got=%b exp=0", pkt_done);
    end
    checks++;
    if (timeout !== 1'b0) begin
      errors++; $display("FAIL reset_timeout got=%b exp=0", timeout);
    end
  endtask

  // All requesters valid, 3-beat packets: grants 0,1,2,3,0, each packet
  // taking one IDLE cycle plus three GRANT cycles.
  task automatic test_round_robin();
    int   order [5];
    int   dones;
    int   p, pkt, g, prev;
    obs_t got, exp_o;
    order = '{0, 1, 2, 3, 0};
    dones = 0;
    do_reset();
    for (int k = 0; k < 4; k++) len[k] = 3;
    avail = 4'b1111;
    for (int c = 0; c <= 20; c++) begin
      settle();
      p   = c % 4;
      pkt = c / 4;
      if (p == 0) begin
        prev  = (pkt == 0) ? 0 : order[pkt-1];
        exp_o = mk(1'b0, 2'(prev), 1'b0, 4'b0000, pkt > 0, 8'h00);
      end else begin
        g     = order[pkt];
        exp_o = mk(1'b1, 2'(g), p == 3, 4'(1 << g), 1'b0, {4'(g), 4'(p - 1)});
      end
      got = observe();
      if (pkt_done) dones++;
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL round_robin cyc=%0d got=%h exp=%h", c, got, exp_o);
      end
      advance();
    end
    checks++;
    if (dones !== 5) begin
      errors++; $display("FAIL round_robin_done_count got=%0d exp=5", dones);
    end
  endtask

  // Single-beat packet on requester 2, then search resumes at requester 3.
  task automatic test_single_beat();
    obs_t e [4];
    obs_t got;
    e[0] = mk(1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[1] = mk(1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 8'h20);
    e[2] = mk(1'b0, 2'd2, 1'b0, 4'b0000, 1'b1, 8'h00);
    e[3] = mk(1'b1, 2'd3, 1'b0, 4'b1000, 1'b0, 8'h30);
    do_reset();
    len[2] = 1;
    for (int c = 0; c < 4; c++) begin
      avail = (c < 2) ? 4'b0100 : 4'b1010;
      settle();
      got = observe();
      checks++;
      if (got !== e[c]) begin
        errors++;
        $display("FAIL single_beat cyc=%0d got=%h exp=%h", c, got, e[c]);
      end
      advance();
    end
  endtask

  // Requester 1 granted under toggling m_tready; requester 0 waits for its tlast.
  task automatic test_backpressure();
    obs_t e [8];
    obs_t got;
    e[0] = mk(1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[1] = mk(1'b1, 2'd1, 1'b0, 4'b0010, 1'b0, 8'h10);
    e[2] = mk(1'b1, 2'd1, 1'b0, 4'b0000, 1'b0, 8'h11);
    e[3] = mk(1'b1, 2'd1, 1'b0, 4'b0010, 1'b0, 8'h11);
    e[4] = mk(1'b1, 2'd1, 1'b1, 4'b0000, 1'b0, 8'h12);
    e[5] = mk(1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 8'h12);
    e[6] = mk(1'b0, 2'd1, 1'b0, 4'b0000, 1'b1, 8'h00);
    e[7] = mk(1'b1, 2'd0, 1'b0, 4'b0001, 1'b0, 8'h00);
    do_reset();
    len[0] = 3;
    len[1] = 3;
    for (int c = 0; c < 8; c++) begin
      avail    = (c == 0) ? 4'b0010 : 4'b0011;
      m_tready = (c % 2 == 1);
      settle();
      got = observe();
      checks++;
      if (got !== e[c]) begin
        errors++;
        $display("FAIL backpressure cyc=%0d got=%h exp=%h", c, got, e[c]);
      end
      advance();
    end
    m_tready = 1'b1;
  endtask

  // enable dropped during a 4-beat packet on requester 3.
  task automatic test_enable_drop();
    obs_t e [10];
    obs_t got;
    e[0] = mk(1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[1] = mk(1'b1, 2'd3, 1'b0, 4'b1000, 1'b0, 8'h30);
    e[2] = mk(1'b1, 2'd3, 1'b0, 4'b1000, 1'b0, 8'h31);
    e[3] = mk(1'b1, 2'd3, 1'b0, 4'b1000, 1'b0, 8'h32);
    e[4] = mk(1'b1, 2'd3, 1'b1, 4'b1000, 1'b0, 8'h33);
    e[5] = mk(1'b0, 2'd3, 1'b0, 4'b0000, 1'b1, 8'h00);
    e[6] = mk(1'b0, 2'd3, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[7] = mk(1'b0, 2'd3, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[8] = mk(1'b0, 2'd3, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[9] = mk(1'b1, 2'd0, 1'b0, 4'b0001, 1'b0, 8'h00);
    do_reset();
    len[3] = 4;
    for (int c = 0; c < 10; c++) begin
      avail  = (c < 5) ? 4'b1000 : 4'b1001;
      enable = (c == 0) || (c >= 8);
      settle();
      got = observe();
      checks++;
      if (got !== e[c]) begin
        errors++;
        $display("FAIL enable_drop cyc=%0d got=%h exp=%h", c, got, e[c]);
      end
      advance();
    end
    enable = 1'b1;
  endtask

  // Reset during beat 2 of 5; rr_ptr was 3 beforehand and must return to 0.
  task automatic test_reset_mid();
    obs_t e [7];
    obs_t got;
    e[0] = mk(1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[1] = mk(1'b1, 2'd2, 1'b1, 4'b0100, 1'b0, 8'h20);
    e[2] = mk(1'b0, 2'd2, 1'b0, 4'b0000, 1'b1, 8'h00);
    e[3] = mk(1'b1, 2'd1, 1'b0, 4'b0010, 1'b0, 8'h10);
    e[4] = mk(1'b0, 2'd1, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[5] = mk(1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[6] = mk(1'b1, 2'd0, 1'b0, 4'b0001, 1'b0, 8'h00);
    do_reset();
    len[2] = 1;
    len[1] = 5;
    for (int c = 0; c < 7; c++) begin
      avail = (c < 2) ? 4'b0100 : (c < 5) ? 4'b0010 : 4'b1001;
      rst   = (c == 4);
      settle();
      got = observe();
      checks++;
      if (got !== e[c]) begin
        errors++;
        $display("FAIL reset_mid cyc=%0d got=%h exp=%h", c, got, e[c]);
      end
      advance();
    end
    rst = 1'b0;
  endtask

  // Clock enable low for two cycles mid-packet freezes the transfer.
  task automatic test_cke_hold();
    obs_t e [6];
    obs_t got;
    e[0] = mk(1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[1] = mk(1'b1, 2'd1, 1'b0, 4'b0010, 1'b0, 8'h10);
    e[2] = mk(1'b0, 2'd1, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[3] = mk(1'b0, 2'd1, 1'b0, 4'b0000, 1'b0, 8'h00);
    e[4] = mk(1'b1, 2'd1, 1'b1, 4'b0010, 1'b0, 8'h11);
    e[5] = mk(1'b0, 2'd1, 1'b0, 4'b0000, 1'b1, 8'h00);
    do_reset();
    avail = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) avail = 4'b0000;
      cke = !(c == 2 || c == 3);
      settle();
      got = observe();
      checks++;
      if (got !== e[c]) begin
        errors++;
        $display("FAIL cke_hold cyc=%0d got=%h exp=%h", c, got, e[c]);
      end
      advance();
    end
    cke = 1'b1;
  endtask

  // Granted requester 1 drops tvalid; with the watchdog built, limit 10 forces a
  // release after 11 stalled GRANT cycles and requester 2 is granted next.
  task automatic test_timeout();
    obs_t got, exp_o;
    timeout_cyc = 16'd10;
    do_reset();
    for (int c = 0; c < 14; c++) begin
      avail = (c == 0) ? 4'b0010 : 4'b0100;
      settle();
      if (c == 0) begin
        exp_o = mk(1'b0, 2'd0, 1'b0, 4'b0000, 1'b0, 8'h00);
      end else begin
        exp_o = mk(1'b0, 2'd1, 1'b0, 4'b0010, 1'b0, 8'h00);
`ifdef IOB_AXIS_PKT_ARBITER_TIMEOUT_EN
        if (c == 12) begin
          exp_o    = mk(1'b0, 2'd1, 1'b0, 4'b0000, 1'b0, 8'h00);
          exp_o.to = 1'b1;
        end
        if (c == 13) exp_o = mk(1'b1, 2'd2, 1'b0, 4'b0100, 1'b0, 8'h20);
`endif
      end
      got = observe();
      checks++;
      if (got !== exp_o) begin
        errors++;
        $display("FAIL timeout cyc=%0d got=%h exp=%h", c, got, exp_o);
      end
      advance();
    end
    timeout_cyc = 16'd0;
  endtask

  initial begin
    cke         = 1'b1;
    rst         = 1'b1;
    enable      = 1'b0;
    m_tready    = 1'b0;
    timeout_cyc = 16'd0;
    avail       = 4'b0000;
    s_tvalid    = 4'b0000;
    s_tlast     = 4'b0000;
    s_tdata     = 32'h0;
    #2;
    test_reset();
    test_round_robin();
    test_single_beat();
    test_backpressure();
    test_enable_drop();
    test_reset_mid();
    test_cke_hold();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog sim_time got=expired exp=finished");
    $fatal(1);
  end

endmodule
